// File: rtl/multi_center_of_mass.sv
// Multi-target color center-of-mass tracker: per-channel pixel qualification and accumulation,
// frame-boundary snapshot, and one shared serial divider that publishes every centroid at once.

module multi_center_of_mass #(
  parameter int CHANNELS  = 2,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 23,
  parameter int X_MAX     = 1024,
  parameter int Y_MAX     = 768,
  parameter int X_OFFSET  = 152,
  parameter int Y_OFFSET  = 144,
  parameter int X_DEFAULT = 512,
  parameter int Y_DEFAULT = 384,
  parameter int MIN_COUNT = 16
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    pixelValid,
  input  logic [17:0]             pixel,
  input  logic [10:0]             x,
  input  logic [9:0]              y,
  input  logic [2*CHANNELS-1:0]   colorSelect,
  input  logic [5*CHANNELS-1:0]   colorMin,
  input  logic [5*CHANNELS-1:0]   colorDiff,
  output logic [CHANNELS-1:0]     included,
  output logic [10*CHANNELS-1:0]  xCenter,
  output logic [10*CHANNELS-1:0]  yCenter,
  output logic [CHANNELS-1:0]     found,
  output logic                    resultValid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int AW1 = ACC_WIDTH + 1;
  localparam int CW1 = CNT_WIDTH + 1;
  localparam int BW  = $clog2(ACC_WIDTH);
  localparam int IW  = 3;
  localparam logic [11:0]          X_LIM   = 12'(X_MAX);
  localparam logic [10:0]          Y_LIM   = 11'(Y_MAX);
  localparam logic [CNT_WIDTH-1:0] MIN_CNT = CNT_WIDTH'(MIN_COUNT);
  localparam logic [9:0]           X_DEF   = 10'(X_DEFAULT);
  localparam logic [9:0]           Y_DEF   = 10'(Y_DEFAULT);
  localparam logic [9:0]           X_OFF   = 10'(X_OFFSET);
  localparam logic [9:0]           Y_OFF   = 10'(Y_OFFSET);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_NEXT, S_PUBLISH} state_t;
  state_t r_state, w_nextState;

  logic [4:0] w_red, w_green, w_blue;
  logic [CHANNELS-1:0][4:0] w_main, w_other1, w_other2, w_min, w_diff;
  logic w_inRange, w_frameStart, w_snapTake, w_unusedPixelBits;

  logic [CHANNELS-1:0][ACC_WIDTH-1:0] r_xSum, r_ySum, r_xSnap, r_ySnap, w_xSat, w_ySat;
  logic [CHANNELS-1:0][AW1-1:0]       w_xWide, w_yWide;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] r_cnt, r_cntSnap, w_cntSat;
  logic r_overrun;

  logic [ACC_WIDTH-1:0] r_quo, w_quoNext, w_dividend;
  logic [CNT_WIDTH-1:0] r_rem, w_remNext, r_divisor, w_divisor;
  logic [CW1-1:0]       w_trial;
  logic                 w_ge, w_enough, w_axisY, w_lastStep, w_lastIdx;
  logic [BW-1:0]        r_bitCnt;
  logic [IW-1:0]        r_idx;
  logic [IW-2:0]        w_chan;
  logic [9:0]           w_result;

  logic [CHANNELS-1:0][9:0] r_pendX, r_pendY, w_pendX, w_pendY, r_xCenter, r_yCenter;
  logic [CHANNELS-1:0]      r_pendFound, w_pendFound, r_found;

  assign w_red             = pixel[17:13];
  assign w_green           = pixel[11:7];
  assign w_blue            = pixel[5:1];
  assign w_unusedPixelBits = pixel[12] ^ pixel[6] ^ pixel[0];
  assign w_inRange         = ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
  assign w_frameStart      = pixelValid && (x == '0) && (y == '0);
  assign busy              = (r_state != S_IDLE);
  assign w_snapTake        = w_frameStart && !busy;
  assign resultValid       = (r_state == S_PUBLISH);
  assign overrun           = r_overrun;
  assign xCenter           = r_xCenter;
  assign yCenter           = r_yCenter;
  assign found             = r_found;

  // Rotate the color fields so "main" is the selected color and the others follow in RGB order
  always_comb begin
    w_main   = '0;
    w_other1 = '0;
    w_other2 = '0;
    w_min    = '0;
    w_diff   = '0;
    included = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_min[c]  = colorMin[5*c +: 5];
      w_diff[c] = colorDiff[5*c +: 5];
      case (colorSelect[2*c +: 2])
        2'd0:    begin w_main[c] = w_red;   w_other1[c] = w_green; w_other2[c] = w_blue;  end
        2'd1:    begin w_main[c] = w_green; w_other1[c] = w_blue;  w_other2[c] = w_red;   end
        default: begin w_main[c] = w_blue;  w_other1[c] = w_red;   w_other2[c] = w_green; end
      endcase
      included[c] = pixelValid && w_inRange && (colorSelect[2*c +: 2] != 2'd3)
                    && (w_main[c] > w_min[c])
                    && (w_other1[c] < w_main[c]) && ((w_main[c] - w_other1[c]) > w_diff[c])
                    && (w_other2[c] < w_main[c]) && ((w_main[c] - w_other2[c]) > w_diff[c]);
    end
  end

  always_comb begin
    w_xWide  = '0;
    w_yWide  = '0;
    w_xSat   = '0;
    w_ySat   = '0;
    w_cntSat = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_xWide[c]  = {1'b0, r_xSum[c]} + AW1'(x);
      w_yWide[c]  = {1'b0, r_ySum[c]} + AW1'(y);
      w_xSat[c]   = w_xWide[c][ACC_WIDTH] ? '1 : w_xWide[c][ACC_WIDTH-1:0];
      w_ySat[c]   = w_yWide[c][ACC_WIDTH] ? '1 : w_yWide[c][ACC_WIDTH-1:0];
      w_cntSat[c] = (&r_cnt[c]) ? r_cnt[c] : r_cnt[c] + CNT_WIDTH'(1);
    end
  end

  // A frame start seen while the divider is still busy drops that frame's snapshot
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_xSum    <= '0;
      r_ySum    <= '0;
      r_cnt     <= '0;
      r_xSnap   <= '0;
      r_ySnap   <= '0;
      r_cntSnap <= '0;
      r_overrun <= 1'b0;
    end else if (pixelValid) begin
      if (w_frameStart) begin
        if (busy) begin
          r_overrun <= 1'b1;
        end else begin
          r_xSnap   <= r_xSum;
          r_ySnap   <= r_ySum;
          r_cntSnap <= r_cnt;
        end
        for (int c = 0; c < CHANNELS; c++) begin
          r_xSum[c] <= included[c] ? ACC_WIDTH'(x) : '0;
          r_ySum[c] <= included[c] ? ACC_WIDTH'(y) : '0;
          r_cnt[c]  <= included[c] ? CNT_WIDTH'(1) : '0;
        end
      end else begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (included[c]) begin
            r_xSum[c] <= w_xSat[c];
            r_ySum[c] <= w_ySat[c];
            r_cnt[c]  <= w_cntSat[c];
          end
        end
      end
    end
  end

  assign w_chan     = r_idx[IW-1:1];
  assign w_axisY    = r_idx[0];
  assign w_lastStep = (r_bitCnt == BW'(ACC_WIDTH - 2));
  assign w_lastIdx  = (r_idx == IW'(2*CHANNELS - 1));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_nextState;
  end

  // NEXT produces the final quotient bit, so LOAD + DIV + NEXT is ACC_WIDTH+1 cycles per divide
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:    if (w_snapTake) w_nextState = S_LOAD;
      S_LOAD:    w_nextState = S_DIV;
      S_DIV:     if (w_lastStep) w_nextState = S_NEXT;
      S_NEXT:    w_nextState = w_lastIdx ? S_PUBLISH : S_LOAD;
      S_PUBLISH: w_nextState = S_IDLE;
      default:   w_nextState = S_IDLE;
    endcase
  end

  assign w_trial   = {r_rem, r_quo[ACC_WIDTH-1]};
  assign w_ge      = (w_trial >= {1'b0, r_divisor});
  assign w_remNext = w_ge ? CNT_WIDTH'(w_trial - {1'b0, r_divisor}) : w_trial[CNT_WIDTH-1:0];
  assign w_quoNext = {r_quo[ACC_WIDTH-2:0], w_ge};
  assign w_enough  = (r_divisor >= MIN_CNT);
  assign w_result  = !w_enough ? (w_axisY ? Y_DEF : X_DEF)
                               : w_quoNext[9:0] + (w_axisY ? Y_OFF : X_OFF);

  always_comb begin
    w_dividend  = '0;
    w_divisor   = '0;
    w_pendX     = r_pendX;
    w_pendY     = r_pendY;
    w_pendFound = r_pendFound;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_chan == (IW-1)'(c)) begin
        w_dividend     = w_axisY ? r_ySnap[c] : r_xSnap[c];
        w_divisor      = r_cntSnap[c];
        w_pendFound[c] = w_enough;
        if (w_axisY) w_pendY[c] = w_result;
        else         w_pendX[c] = w_result;
      end
    end
  end

  // Results collect in pending registers and reach the outputs together on entry to PUBLISH
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_quo       <= '0;
      r_rem       <= '0;
      r_divisor   <= '0;
      r_bitCnt    <= '0;
      r_idx       <= '0;
      r_pendFound <= '0;
      r_found     <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_pendX[c]   <= X_DEF;
        r_pendY[c]   <= Y_DEF;
        r_xCenter[c] <= X_DEF;
        r_yCenter[c] <= Y_DEF;
      end
    end else begin
      case (r_state)
        S_IDLE: r_idx <= '0;
        S_LOAD: begin
          r_quo     <= w_dividend;
          r_rem     <= '0;
          r_divisor <= w_divisor;
          r_bitCnt  <= '0;
        end
        S_DIV: begin
          r_quo    <= w_quoNext;
          r_rem    <= w_remNext;
          r_bitCnt <= r_bitCnt + BW'(1);
        end
        S_NEXT: begin
          r_quo       <= w_quoNext;
          r_rem       <= w_remNext;
          r_pendX     <= w_pendX;
          r_pendY     <= w_pendY;
          r_pendFound <= w_pendFound;
          r_idx       <= r_idx + IW'(1);
          if (w_lastIdx) begin
            r_xCenter <= w_pendX;
            r_yCenter <= w_pendY;
            r_found   <= w_pendFound;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_center_of_mass.sv
// Testbench for multi_center_of_mass: directed and randomized pixel frames checked against
// an arithmetic centroid model with immediate assertions.

module tb_multi_center_of_mass;

  localparam int CH = 2;

  logic            clk = 1'b0;
  logic            resetN;
  logic            pixelValid;
  logic [17:0]     pixel;
  logic [10:0]     x;
  logic [9:0]      y;
  logic [2*CH-1:0] colorSelect;
  logic [5*CH-1:0] colorMin;
  logic [5*CH-1:0] colorDiff;
  logic [CH-1:0]   included;
  logic [10*CH-1:0] xCenter;
  logic [10*CH-1:0] yCenter;
  logic [CH-1:0]   found;
  logic            resultValid;
  logic            busy;
  logic            overrun;

  int     nAssert, nFail;
  int     cfgSel[CH], cfgMin[CH], cfgDiff[CH];
  longint mSx[CH], mSy[CH], mCnt[CH];
  int     expX[CH], expY[CH], expF[CH];
  logic [CH-1:0] lastIncl;

  multi_center_of_mass dut (
    .clk(clk), .resetN(resetN), .pixelValid(pixelValid), .pixel(pixel), .x(x), .y(y),
    .colorSelect(colorSelect), .colorMin(colorMin), .colorDiff(colorDiff),
    .included(included), .xCenter(xCenter), .yCenter(yCenter), .found(found),
    .resultValid(resultValid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] mkPix(input int r, input int g, input int b);
    return {5'(r), 1'b0, 5'(g), 1'b0, 5'(b), 1'b0};
  endfunction

  function automatic bit modelQual(input int c, input bit v, input logic [17:0] p,
                                   input int xx, input int yy);
    int col[3];
    int m, o1, o2;
    col[0] = int'(p[17:13]);
    col[1] = int'(p[11:7]);
    col[2] = int'(p[5:1]);
    if (!v || cfgSel[c] == 3 || xx >= 1024 || yy >= 768) return 1'b0;
    m  = col[cfgSel[c]];
    o1 = col[(cfgSel[c] + 1) % 3];
    o2 = col[(cfgSel[c] + 2) % 3];
    return (m > cfgMin[c]) && (m - o1 > cfgDiff[c]) && (m - o2 > cfgDiff[c]);
  endfunction

  function automatic int expCenter(input longint s, input longint n, input int off, input int dflt);
    if (n < 16) return dflt;
    return int'(((s / n) + off) % 1024);
  endfunction

  task automatic applyConfig();
    for (int c = 0; c < CH; c++) begin
      colorSelect[2*c +: 2] = 2'(cfgSel[c]);
      colorMin[5*c +: 5]    = 5'(cfgMin[c]);
      colorDiff[5*c +: 5]   = 5'(cfgDiff[c]);
    end
  endtask

  task automatic clearModel();
    for (int c = 0; c < CH; c++) begin
      mSx[c] = 0; mSy[c] = 0; mCnt[c] = 0;
    end
  endtask

  task automatic snapshotModel();
    for (int c = 0; c < CH; c++) begin
      expX[c] = expCenter(mSx[c], mCnt[c], 152, 512);
      expY[c] = expCenter(mSy[c], mCnt[c], 144, 384);
      expF[c] = (mCnt[c] >= 16) ? 1 : 0;
    end
  endtask

  // One pixel per call; the model sums are kept as plain integers (test frames never saturate)
  task automatic applyStimulus(input bit v, input logic [17:0] p, input int xx, input int yy);
    logic [CH-1:0] expIncl;
    @(negedge clk);
    pixelValid = v;
    pixel      = p;
    x          = 11'(xx);
    y          = 10'(yy);
    #1;
    for (int c = 0; c < CH; c++) expIncl[c] = modelQual(c, v, p, xx, yy);
    lastIncl = included;
    checkOutput("included", 32'(included), 32'(expIncl));
    for (int c = 0; c < CH; c++) begin
      if (v && xx == 0 && yy == 0) begin
        mSx[c]  = expIncl[c] ? xx : 0;
        mSy[c]  = expIncl[c] ? yy : 0;
        mCnt[c] = expIncl[c] ? 1 : 0;
      end else if (expIncl[c]) begin
        mSx[c] += xx; mSy[c] += yy; mCnt[c] += 1;
      end
    end
    @(posedge clk);
    #1;
    pixelValid = 1'b0;
  endtask

  task automatic checkPublished(input string tag);
    for (int c = 0; c < CH; c++) begin
      checkOutput($sformatf("%s xCenter%0d", tag, c), 32'(xCenter[10*c +: 10]), 32'(expX[c]));
      checkOutput($sformatf("%s yCenter%0d", tag, c), 32'(yCenter[10*c +: 10]), 32'(expY[c]));
      checkOutput($sformatf("%s found%0d", tag, c), 32'(found[c]), 32'(expF[c]));
    end
  endtask

  task automatic endFrame(input string tag);
    int cycles;
    snapshotModel();
    applyStimulus(1'b1, 18'd0, 0, 0);
    cycles = 1;
    while (resultValid !== 1'b1 && cycles < 400) begin
      @(posedge clk); #1; cycles++;
    end
    checkOutput({tag, " latency"}, 32'(cycles), 32'd133);
    checkPublished(tag);
    @(posedge clk); #1;
    checkOutput({tag, " strobe one cycle"}, 32'(resultValid), 32'd0);
    checkOutput({tag, " busy cleared"}, 32'(busy), 32'd0);
  endtask

  task automatic checkDefaults(input string tag);
    for (int c = 0; c < CH; c++) begin
      checkOutput($sformatf("%s xCenter%0d", tag, c), 32'(xCenter[10*c +: 10]), 32'd512);
      checkOutput($sformatf("%s yCenter%0d", tag, c), 32'(yCenter[10*c +: 10]), 32'd384);
    end
    checkOutput({tag, " found"}, 32'(found), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " resultValid"}, 32'(resultValid), 32'd0);
    checkOutput({tag, " overrun"}, 32'(overrun), 32'd0);
  endtask

  task automatic redBlock(input int x0, input int y0);
    for (int yy = y0; yy < y0 + 4; yy++)
      for (int xx = x0; xx < x0 + 4; xx++)
        applyStimulus(1'b1, mkPix(31, 0, 0), xx, yy);
  endtask

  int bV[11]  = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1};
  int bR[11]  = '{8, 9, 9, 9, 31, 31, 31, 31, 0, 9, 9};
  int bG[11]  = '{0, 1, 0, 0, 0, 0, 0, 0, 31, 0, 0};
  int bB[11]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  int bX[11]  = '{10, 10, 10, 10, 1024, 1023, 10, 10, 10, 10, 10};
  int bY[11]  = '{10, 10, 10, 10, 10, 767, 768, 10, 10, 10, 10};
  int bMin[11] = '{8, 8, 8, 8, 8, 8, 8, 8, 8, 9, 8};
  int bExp[11] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    int cycles, pulses, d;
    int col[3];
    logic [17:0] p;
    nAssert = 0; nFail = 0;
    resetN = 1'b0; pixelValid = 1'b0; pixel = '0; x = '0; y = '0;
    cfgSel = '{0, 1}; cfgMin = '{8, 8}; cfgDiff = '{8, 8};
    applyConfig();
    clearModel();
    repeat (2) @(posedge clk);
    #1;
    checkDefaults("reset");
    @(negedge clk) resetN = 1'b1;

    endFrame("boot");
    redBlock(100, 50);
    endFrame("red16");
    checkOutput("red16 const x0", 32'(xCenter[9:0]), 32'd253);
    checkOutput("red16 const y0", 32'(yCenter[9:0]), 32'd195);
    checkOutput("red16 const found", 32'(found), 32'b01);

    for (int i = 0; i < 10; i++) applyStimulus(1'b1, mkPix(31, 0, 0), 200 + i, 300);
    endFrame("red10");
    checkOutput("red10 const x0", 32'(xCenter[9:0]), 32'd512);
    checkOutput("red10 const found", 32'(found), 32'b00);

    cfgSel = '{0, 3}; cfgMin = '{8, 0}; cfgDiff = '{8, 0};
    for (int i = 0; i < 11; i++) begin
      cfgMin[0] = bMin[i];
      applyConfig();
      applyStimulus(bV[i] != 0, mkPix(bR[i], bG[i], bB[i]), bX[i], bY[i]);
      checkOutput($sformatf("boundary %0d", i), 32'(lastIncl), 32'(bExp[i]));
    end
    cfgSel = '{0, 1}; cfgMin = '{8, 8}; cfgDiff = '{8, 8};
    applyConfig();
    endFrame("boundary");

    redBlock(900, 700);
    endFrame("wrap");
    checkOutput("wrap const x0", 32'(xCenter[9:0]), 32'd29);
    checkOutput("wrap const y0", 32'(yCenter[9:0]), 32'd845);

    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < CH; c++) begin
        cfgSel[c]  = int'($urandom_range(0, 3));
        cfgMin[c]  = int'($urandom_range(0, 15));
        cfgDiff[c] = int'($urandom_range(0, 10));
      end
      applyConfig();
      for (int i = 0; i < 60; i++) begin
        d = int'($urandom_range(0, 2));
        for (int k = 0; k < 3; k++)
          col[k] = (k == d) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 12));
        p = ($urandom_range(0, 3) == 0) ? 18'($urandom) : mkPix(col[0], col[1], col[2]);
        applyStimulus($urandom_range(0, 7) != 0, p,
                      int'($urandom_range(1, 1100)), int'($urandom_range(0, 800)));
      end
      endFrame($sformatf("random%0d", f));
    end

    cfgSel = '{0, 1}; cfgMin = '{8, 8}; cfgDiff = '{8, 8};
    applyConfig();
    redBlock(300, 400);
    snapshotModel();
    applyStimulus(1'b1, 18'd0, 0, 0);
    cycles = 1;
    repeat (49) begin @(posedge clk); #1; cycles++; end
    applyStimulus(1'b1, 18'd0, 0, 0);
    cycles++;
    checkOutput("overrun set", 32'(overrun), 32'd1);
    while (resultValid !== 1'b1 && cycles < 400) begin
      @(posedge clk); #1; cycles++;
    end
    checkOutput("overrun latency", 32'(cycles), 32'd133);
    checkPublished("overrun");
    checkOutput("overrun const x0", 32'(xCenter[9:0]), 32'd453);
    checkOutput("overrun const y0", 32'(yCenter[9:0]), 32'd545);
    pulses = 0;
    repeat (200) begin @(posedge clk); #1; if (resultValid === 1'b1) pulses++; end
    checkOutput("dropped frame strobes", 32'(pulses), 32'd0);
    checkOutput("overrun sticky", 32'(overrun), 32'd1);

    redBlock(600, 200);
    applyStimulus(1'b1, 18'd0, 0, 0);
    repeat (69) begin @(posedge clk); #1; end
    #2 resetN = 1'b0;
    #1;
    checkDefaults("midreset");
    clearModel();
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    pulses = 0;
    repeat (150) begin @(posedge clk); #1; if (resultValid === 1'b1) pulses++; end
    checkOutput("midreset no strobe", 32'(pulses), 32'd0);
    endFrame("afterReset boot");
    redBlock(500, 600);
    endFrame("afterReset");
    checkOutput("afterReset const x0", 32'(xCenter[9:0]), 32'd653);
    checkOutput("afterReset const y0", 32'(yCenter[9:0]), 32'd745);
    checkOutput("afterReset const found", 32'(found), 32'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
